// File: rtl/slow_bus_ctrl.sv
// slow_bus_ctrl
// Stretches CPU accesses that hit 1 MHz peripherals. A slow address raises
// mhz1_enable toward the clock-enable generator. One peripheral strobe is
// issued on the first 1 MHz enable after the generator has sampled the
// request. Read data is then held for the CPU until the next slow read.
module slow_bus_ctrl #(
  parameter bit FREDJIM_SLOW = 1'b1
) (
  input  logic        clk_48m,
  input  logic        reset,
  input  logic        cpu_clken,
  input  logic        mhz2_clken,
  input  logic        mhz1_clken,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rnw,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  periph_din,
  output logic        mhz1_enable,
  output logic [7:0]  periph_addr,
  output logic [2:0]  periph_sel,
  output logic        periph_rnw,
  output logic [7:0]  periph_dout,
  output logic        periph_stb,
  output logic [7:0]  cpu_din,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_WAIT1M = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        decode_slot_q;
  logic        mhz1_enable_q;
  logic [7:0]  periph_addr_q;
  logic [2:0]  periph_sel_q;
  logic        periph_rnw_q;
  logic [7:0]  periph_dout_q;
  logic [7:0]  cpu_din_q;

  logic        sheila_slow;
  logic        fred_slow;
  logic        jim_slow;
  logic        slow_hit;
  logic [2:0]  sel_dec;
  logic        latch_req;
  logic        stb;

  // Address decode: which slow region (if any) the current CPU address hits.
  always_comb begin
    sheila_slow = 1'b0;
    if (cpu_addr[15:8] == 8'hFE) begin
      case (cpu_addr[7:5])
        3'b000,              // FE00-FE1F
        3'b010, 3'b011,      // FE40-FE7F
        3'b110:              // FEC0-FEDF
          sheila_slow = 1'b1;
        default:
          sheila_slow = 1'b0;
      endcase
    end
    fred_slow = FREDJIM_SLOW && (cpu_addr[15:8] == 8'hFC);
    jim_slow  = FREDJIM_SLOW && (cpu_addr[15:8] == 8'hFD);
    sel_dec   = {jim_slow, fred_slow, sheila_slow};
    slow_hit  = |sel_dec;
  end

  // Next-state logic: arm on a slow decode, wait for the generator's sampling
  // edge, strobe on the following 1 MHz enable, then release on the CPU slot.
  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    stb       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (decode_slot_q && slow_hit) begin
          state_d   = ST_ARMED;
          latch_req = 1'b1;
        end
      end
      ST_ARMED: begin
        // A 1 MHz enable coinciding with this 2 MHz edge is deliberately ignored.
        if (mhz2_clken) begin
          state_d = ST_WAIT1M;
        end
      end
      ST_WAIT1M: begin
        if (mhz1_clken) begin
          state_d = ST_DONE;
          stb     = 1'b1;
        end
      end
      ST_DONE: begin
        if (cpu_clken) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Reset must suppress a strobe that would coincide with it.
    if (reset) begin
      stb = 1'b0;
    end
  end

  // State register, decode slot delay and registered stretch request.
  always_ff @(posedge clk_48m) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      decode_slot_q <= 1'b0;
      mhz1_enable_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      decode_slot_q <= cpu_clken;
      mhz1_enable_q <= (state_d == ST_ARMED) || (state_d == ST_WAIT1M);
    end
  end

  // Access attributes latched when the request is armed; held until re-armed.
  always_ff @(posedge clk_48m) begin
    if (reset) begin
      periph_addr_q <= 8'h00;
      periph_sel_q  <= 3'b000;
      periph_rnw_q  <= 1'b1;
    end else if (latch_req) begin
      periph_addr_q <= cpu_addr[7:0];
      periph_sel_q  <= sel_dec;
      periph_rnw_q  <= cpu_rnw;
    end
  end

  // Write data captured on the strobe; read data returned to the CPU.
  always_ff @(posedge clk_48m) begin
    if (reset) begin
      periph_dout_q <= 8'h00;
      cpu_din_q     <= 8'hFF;
    end else if (stb) begin
      periph_dout_q <= cpu_dout;
      if (periph_rnw_q) begin
        cpu_din_q <= periph_din;
      end
    end
  end

  assign mhz1_enable = mhz1_enable_q;
  assign periph_addr = periph_addr_q;
  assign periph_sel  = periph_sel_q;
  assign periph_rnw  = periph_rnw_q;
  // The peripheral sees the live CPU data during the strobe cycle itself.
  assign periph_dout = stb ? cpu_dout : periph_dout_q;
  assign periph_stb  = stb;
  assign cpu_din     = cpu_din_q;
  assign busy        = (state_q != ST_IDLE);

  // At most one region is ever selected.
  a_sel_onehot: assert property (@(posedge clk_48m) disable iff (reset)
    $onehot0(periph_sel_q));

  // A strobe only happens while an access is in flight.
  a_stb_busy: assert property (@(posedge clk_48m) disable iff (reset)
    periph_stb |-> busy);

endmodule

// File: tb/tb_slow_bus_ctrl.sv
// Directed bench for slow_bus_ctrl: models the 48-cycle clock-enable counter,
// drives CPU slots by hand and checks each cycle against hand-derived values.
`timescale 1ns/1ps
module tb_slow_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_clken = 1'b0;
  logic        mhz2_clken;
  logic        mhz1_clken;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_rnw = 1'b1;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  periph_din = 8'h00;

  logic        mhz1_enable, periph_rnw, periph_stb, busy;
  logic [7:0]  periph_addr, periph_dout, cpu_din;
  logic [2:0]  periph_sel;

  logic        mhz1_enable_0, periph_rnw_0, periph_stb_0, busy_0;
  logic [7:0]  periph_addr_0, periph_dout_0, cpu_din_0;
  logic [2:0]  periph_sel_0;

  int checks = 0;
  int fails  = 0;
  logic [5:0] cnt = 6'd0;

  always #10 clk = ~clk;

  // Free-running 48-cycle phase counter standing in for the enable generator.
  always @(posedge clk) cnt <= (cnt == 6'd47) ? 6'd0 : cnt + 6'd1;
  assign mhz2_clken = (cnt == 6'd23) || (cnt == 6'd47);
  assign mhz1_clken = (cnt == 6'd47);

  slow_bus_ctrl #(.FREDJIM_SLOW(1'b1)) dut (
    .clk_48m(clk), .reset(reset), .cpu_clken(cpu_clken),
    .mhz2_clken(mhz2_clken), .mhz1_clken(mhz1_clken),
    .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_dout(cpu_dout),
    .periph_din(periph_din), .mhz1_enable(mhz1_enable),
    .periph_addr(periph_addr), .periph_sel(periph_sel),
    .periph_rnw(periph_rnw), .periph_dout(periph_dout),
    .periph_stb(periph_stb), .cpu_din(cpu_din), .busy(busy)
  );

  slow_bus_ctrl #(.FREDJIM_SLOW(1'b0)) dut0 (
    .clk_48m(clk), .reset(reset), .cpu_clken(cpu_clken),
    .mhz2_clken(mhz2_clken), .mhz1_clken(mhz1_clken),
    .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_dout(cpu_dout),
    .periph_din(periph_din), .mhz1_enable(mhz1_enable_0),
    .periph_addr(periph_addr_0), .periph_sel(periph_sel_0),
    .periph_rnw(periph_rnw_0), .periph_dout(periph_dout_0),
    .periph_stb(periph_stb_0), .cpu_din(cpu_din_0), .busy(busy_0)
  );

  // Advance to the falling edge of the cycle whose counter equals n.
  task automatic goto_cnt(input int n);
    int guard = 0;
    @(negedge clk);
    while (cnt != n[5:0] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cnt != n[5:0]) begin
      fails++;
      $display("FAIL goto_cnt: counter=%0d required=%0d", cnt, n);
    end
  endtask

  // Give the DONE state its completing CPU slot with a fast address.
  task automatic finish_access();
    cpu_addr  = 16'h0000;
    cpu_rnw   = 1'b1;
    cpu_clken = 1'b1;
    @(negedge clk);
    cpu_clken = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (mhz1_enable !== 1'b0) begin fails++; $display("FAIL rst_en: got=%b want=0", mhz1_enable); end
    checks++; if (periph_stb !== 1'b0) begin fails++; $display("FAIL rst_stb: got=%b want=0", periph_stb); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got=%b want=0", busy); end
    checks++; if (periph_addr !== 8'h00) begin fails++; $display("FAIL rst_addr: got=%h want=00", periph_addr); end
    checks++; if (periph_sel !== 3'b000) begin fails++; $display("FAIL rst_sel: got=%b want=000", periph_sel); end
    checks++; if (periph_rnw !== 1'b1) begin fails++; $display("FAIL rst_rnw: got=%b want=1", periph_rnw); end
    checks++; if (periph_dout !== 8'h00) begin fails++; $display("FAIL rst_dout: got=%h want=00", periph_dout); end
    checks++; if (cpu_din !== 8'hFF) begin fails++; $display("FAIL rst_din: got=%h want=ff", cpu_din); end
    checks++; if (cpu_din_0 !== 8'hFF || busy_0 !== 1'b0) begin fails++; $display("FAIL rst_dut0: din=%h busy=%b want ff/0", cpu_din_0, busy_0); end
    @(negedge clk);
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_slot0_read();
    logic exp_en, exp_stb;
    goto_cnt(0);
    cpu_addr = 16'hFE40; cpu_rnw = 1'b1; periph_din = 8'h5A;
    for (int t = 0; t <= 48; t++) begin
      if (t > 0) @(negedge clk);
      cpu_clken = (t == 0);
      #1;
      exp_en  = (t >= 2) && (t <= 47);
      exp_stb = (t == 47);
      checks++; if (mhz1_enable !== exp_en) begin fails++; $display("FAIL rd0_en t=%0d: got=%b want=%b", t, mhz1_enable, exp_en); end
      checks++; if (periph_stb !== exp_stb) begin fails++; $display("FAIL rd0_stb t=%0d: got=%b want=%b", t, periph_stb, exp_stb); end
      if (t == 47) begin
        checks++; if (periph_sel !== 3'b001) begin fails++; $display("FAIL rd0_sel: got=%b want=001", periph_sel); end
        checks++; if (periph_addr !== 8'h40) begin fails++; $display("FAIL rd0_addr: got=%h want=40", periph_addr); end
        checks++; if (periph_rnw !== 1'b1) begin fails++; $display("FAIL rd0_rnw: got=%b want=1", periph_rnw); end
      end
      if (t == 48) begin
        checks++; if (cpu_din !== 8'h5A) begin fails++; $display("FAIL rd0_din: got=%h want=5a", cpu_din); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rd0_done_busy: got=%b want=1", busy); end
      end
    end
    finish_access();
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rd0_idle: got=%b want=0", busy); end
    $display("test_slot0_read done: cpu_din=%h", cpu_din);
  endtask

  task automatic test_slot24_write();
    logic exp_en, exp_stb;
    goto_cnt(24);
    cpu_addr = 16'hFE60; cpu_rnw = 1'b0; cpu_dout = 8'h3C; periph_din = 8'hEE;
    for (int t = 0; t <= 72; t++) begin
      if (t > 0) @(negedge clk);
      cpu_clken = (t == 0);
      #1;
      exp_en  = (t >= 2) && (t <= 71);
      exp_stb = (t == 71);
      checks++; if (mhz1_enable !== exp_en) begin fails++; $display("FAIL wr24_en t=%0d: got=%b want=%b", t, mhz1_enable, exp_en); end
      checks++; if (periph_stb !== exp_stb) begin fails++; $display("FAIL wr24_stb t=%0d: got=%b want=%b", t, periph_stb, exp_stb); end
      if (t == 71) begin
        checks++; if (periph_dout !== 8'h3C) begin fails++; $display("FAIL wr24_dout: got=%h want=3c", periph_dout); end
        checks++; if (periph_rnw !== 1'b0) begin fails++; $display("FAIL wr24_rnw: got=%b want=0", periph_rnw); end
        checks++; if (periph_addr !== 8'h60 || periph_sel !== 3'b001) begin fails++; $display("FAIL wr24_addr: got=%h/%b want=60/001", periph_addr, periph_sel); end
      end
      if (t == 72) begin
        checks++; if (cpu_din !== 8'h5A) begin fails++; $display("FAIL wr24_din: got=%h want=5a", cpu_din); end
      end
    end
    finish_access();
    cpu_dout = 8'h00;
    $display("test_slot24_write done: cpu_din=%h", cpu_din);
  endtask

  task automatic test_fredjim();
    logic exp_stb;
    goto_cnt(0);
    cpu_addr = 16'hFD12; cpu_rnw = 1'b1; periph_din = 8'hA5;
    for (int t = 0; t <= 48; t++) begin
      if (t > 0) @(negedge clk);
      cpu_clken = (t == 0);
      #1;
      exp_stb = (t == 47);
      checks++; if (mhz1_enable_0 !== 1'b0 || busy_0 !== 1'b0) begin fails++; $display("FAIL jim_off t=%0d: en=%b busy=%b want 0/0", t, mhz1_enable_0, busy_0); end
      checks++; if (periph_stb !== exp_stb) begin fails++; $display("FAIL jim_stb t=%0d: got=%b want=%b", t, periph_stb, exp_stb); end
      if (t == 47) begin
        checks++; if (periph_sel !== 3'b100) begin fails++; $display("FAIL jim_sel: got=%b want=100", periph_sel); end
        checks++; if (periph_addr !== 8'h12) begin fails++; $display("FAIL jim_addr: got=%h want=12", periph_addr); end
      end
      if (t == 48) begin
        checks++; if (cpu_din !== 8'hA5) begin fails++; $display("FAIL jim_din: got=%h want=a5", cpu_din); end
      end
    end
    finish_access();
    $display("test_fredjim done");
  endtask

  task automatic test_decode_edges();
    logic [15:0] addr_tab [0:16];
    logic        slow_tab [0:16];
    logic [2:0]  sel_tab  [0:16];
    logic        exp_on;
    addr_tab = '{16'hFE00, 16'hFE1F, 16'hFE20, 16'hFE3F, 16'hFE40, 16'hFE7F,
                 16'hFE80, 16'hFEBF, 16'hFEC0, 16'hFEDF, 16'hFEE0, 16'hFC00,
                 16'hFDFF, 16'hFBFF, 16'h8000, 16'h0000, 16'hFF00};
    slow_tab = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    sel_tab  = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000,
                 3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b100, 3'b000,
                 3'b000, 3'b000, 3'b000};
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      goto_cnt(0);
      cpu_addr = addr_tab[i]; cpu_rnw = 1'b1;
      for (int t = 0; t < 48; t++) begin
        if (t > 0) @(negedge clk);
        cpu_clken = (t == 0);
        reset = 1'b0;
        #1;
        exp_on = slow_tab[i] && (t == 2);
        checks++; if (mhz1_enable !== exp_on || busy !== exp_on) begin fails++; $display("FAIL dec_%h t=%0d: en=%b busy=%b want=%b", addr_tab[i], t, mhz1_enable, busy, exp_on); end
        if (t == 2) begin
          checks++; if (periph_sel !== sel_tab[i]) begin fails++; $display("FAIL dec_sel_%h: got=%b want=%b", addr_tab[i], periph_sel, sel_tab[i]); end
          // Abort the access so the next entry starts from reset state.
          reset = slow_tab[i];
        end
      end
      $display("decode %h: slow=%b sel=%b", addr_tab[i], slow_tab[i], sel_tab[i]);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_en, exp_stb;
    int   n_stb;
    n_stb = 0;
    goto_cnt(0);
    cpu_addr = 16'hFE00; cpu_rnw = 1'b1; periph_din = 8'h11;
    for (int t = 0; t <= 96; t++) begin
      if (t > 0) @(negedge clk);
      cpu_clken = (t == 0) || (t == 48);
      if (t == 48) begin
        cpu_addr = 16'hFEC0; periph_din = 8'h22;
      end
      #1;
      exp_en  = ((t >= 2) && (t <= 47)) || ((t >= 50) && (t <= 95));
      exp_stb = (t == 47) || (t == 95);
      if (periph_stb === 1'b1) n_stb++;
      checks++; if (mhz1_enable !== exp_en) begin fails++; $display("FAIL b2b_en t=%0d: got=%b want=%b", t, mhz1_enable, exp_en); end
      checks++; if (periph_stb !== exp_stb) begin fails++; $display("FAIL b2b_stb t=%0d: got=%b want=%b", t, periph_stb, exp_stb); end
      if (t == 49) begin
        checks++; if (cpu_din !== 8'h11) begin fails++; $display("FAIL b2b_din1: got=%h want=11", cpu_din); end
      end
      if (t == 95) begin
        checks++; if (periph_addr !== 8'hC0 || periph_sel !== 3'b001) begin fails++; $display("FAIL b2b_addr2: got=%h/%b want=c0/001", periph_addr, periph_sel); end
      end
      if (t == 96) begin
        checks++; if (cpu_din !== 8'h22) begin fails++; $display("FAIL b2b_din2: got=%h want=22", cpu_din); end
      end
    end
    checks++; if (n_stb != 2) begin fails++; $display("FAIL b2b_count: got=%0d want=2", n_stb); end
    finish_access();
    $display("test_back_to_back done: strobes=%0d", n_stb);
  endtask

  task automatic test_reset_midaccess();
    // Reset well inside WAIT1M.
    goto_cnt(0);
    cpu_addr = 16'hFE40; cpu_rnw = 1'b1; periph_din = 8'h77;
    for (int t = 0; t <= 48; t++) begin
      if (t > 0) @(negedge clk);
      cpu_clken = (t == 0);
      reset = (t == 30);
      #1;
      checks++; if (periph_stb !== 1'b0) begin fails++; $display("FAIL rstA_stb t=%0d: got=%b want=0", t, periph_stb); end
      if (t == 31) begin
        checks++; if (mhz1_enable !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstA_idle: en=%b busy=%b want 0/0", mhz1_enable, busy); end
        checks++; if (cpu_din !== 8'hFF) begin fails++; $display("FAIL rstA_din: got=%h want=ff", cpu_din); end
      end
    end
    // Reset on the very cycle the strobe would fire.
    goto_cnt(0);
    cpu_addr = 16'hFE40; cpu_rnw = 1'b1; periph_din = 8'h66;
    for (int t = 0; t <= 49; t++) begin
      if (t > 0) @(negedge clk);
      cpu_clken = (t == 0);
      reset = (t == 47);
      #1;
      checks++; if (periph_stb !== 1'b0) begin fails++; $display("FAIL rstB_stb t=%0d: got=%b want=0", t, periph_stb); end
      if (t == 46) begin
        checks++; if (mhz1_enable !== 1'b1) begin fails++; $display("FAIL rstB_pre_en: got=%b want=1", mhz1_enable); end
      end
      if (t == 48) begin
        checks++; if (mhz1_enable !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstB_idle: en=%b busy=%b want 0/0", mhz1_enable, busy); end
        checks++; if (cpu_din !== 8'hFF) begin fails++; $display("FAIL rstB_din: got=%h want=ff", cpu_din); end
      end
    end
    reset = 1'b0;
    $display("test_reset_midaccess done");
  endtask

  initial begin
    test_reset();
    test_slot0_read();
    test_slot24_write();
    test_fredjim();
    test_decode_edges();
    test_back_to_back();
    test_reset_midaccess();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
